// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes,
// immediate formats and the packed control bundle carried across ID/EX.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src_imm;
        logic    alu_src_pc;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                     fmt = IMM_S;
            OPC_BRANCH:                    fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
            OPC_JAL:                       fmt = IMM_J;
            default:                       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: extracts the format-specific immediate
// from an RV32I instruction word and sign-extends it to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt_of(instr_i[6:0]))
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Size cast of a signed value sign-extends when XLEN > 32.
        imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, writeback bypass around the register
// file, load-use hazard detection and the ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src_imm,
    output logic              ex_alu_src_pc,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_b5;
    logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]   imm_dec;
    logic [XLEN-1:0]   rs1_val_dec, rs2_val_dec;
    ctrl_t             ctrl_dec;
    logic              use1_dec, use2_dec;
    logic              hazard;

    logic              ex_valid_q,   ex_valid_d;
    ctrl_t             ex_ctrl_q,    ex_ctrl_d;
    logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]   ex_rs1_val_q, ex_rs1_val_d;
    logic [XLEN-1:0]   ex_rs2_val_q, ex_rs2_val_d;
    logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
    logic [REG_AW-1:0] ex_rs1_q,     ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q,     ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
    logic [2:0]        ex_funct3_q,  ex_funct3_d;

    assign opcode    = if_instr[6:0];
    assign funct3    = if_instr[14:12];
    assign funct7_b5 = if_instr[30];
    assign rd_idx    = if_instr[11:7];
    assign rs1_idx   = if_instr[19:15];
    assign rs2_idx   = if_instr[24:20];
    assign rf_raddr1 = rs1_idx;
    assign rf_raddr2 = rs2_idx;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (if_instr),
        .imm_o   (imm_dec)
    );

    // The register file writes on the same edge that captures ID/EX, so a
    // matching writeback must be forwarded here or the old value is latched.
    function automatic logic [XLEN-1:0] bypass(
        input logic [REG_AW-1:0] idx,
        input logic [XLEN-1:0]   rdata
    );
        if (idx == '0)
            return '0;
        else if (wb_we && (wb_waddr == idx))
            return wb_wdata;
        else
            return rdata;
    endfunction

    function automatic alu_op_t alu_from_funct3(
        input logic [2:0] f3,
        input logic       b5,
        input logic       is_op
    );
        case (f3)
            3'b000:  return (is_op && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign rs1_val_dec = bypass(rs1_idx, rf_rdata1);
    assign rs2_val_dec = bypass(rs2_idx, rf_rdata2);

    always_comb begin
        ctrl_dec = '0;
        use1_dec = 1'b1;
        use2_dec = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_dec.alu_op      = ALU_PASS_B;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
                use1_dec             = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl_dec.alu_op      = ALU_ADD;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.alu_src_pc  = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
                use1_dec             = 1'b0;
            end
            OPC_JAL: begin
                ctrl_dec.alu_op      = ALU_ADD;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.jump        = 1'b1;
                use1_dec             = 1'b0;
            end
            OPC_JALR: begin
                ctrl_dec.alu_op      = ALU_ADD;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
                ctrl_dec.jump        = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_dec.alu_op      = ALU_SUB;
                ctrl_dec.branch      = 1'b1;
                use2_dec             = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_dec.alu_op      = ALU_ADD;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.mem_read    = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                ctrl_dec.alu_op      = ALU_ADD;
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.mem_write   = 1'b1;
                use2_dec             = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl_dec.alu_op      = alu_from_funct3(funct3, funct7_b5, 1'b0);
                ctrl_dec.alu_src_imm = 1'b1;
                ctrl_dec.reg_write   = 1'b1;
            end
            OPC_OP: begin
                ctrl_dec.alu_op      = alu_from_funct3(funct3, funct7_b5, 1'b1);
                ctrl_dec.reg_write   = 1'b1;
                use2_dec             = 1'b1;
            end
            default: begin
                ctrl_dec.illegal     = 1'b1;
            end
        endcase
    end

    assign hazard = if_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                    ((use1_dec && (rs1_idx == ex_rd_q)) || (use2_dec && (rs2_idx == ex_rd_q)));

    assign id_ready = !ex_stall && !hazard && rst_n;

    // Data fields follow the decoder whenever EX is not stalled; only valid
    // and control need the bubble/flush treatment to stay architecturally safe.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_imm_d     = ex_imm_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_funct3_d  = ex_funct3_q;
        if (!ex_stall) begin
            ex_pc_d      = if_pc;
            ex_rs1_val_d = rs1_val_dec;
            ex_rs2_val_d = rs2_val_dec;
            ex_imm_d     = imm_dec;
            ex_rs1_d     = rs1_idx;
            ex_rs2_d     = rs2_idx;
            ex_rd_d      = rd_idx;
            ex_funct3_d  = funct3;
        end
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (ex_stall) begin
            ex_valid_d = ex_valid_q;
            ex_ctrl_d  = ex_ctrl_q;
        end else if (hazard || !if_valid) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = ctrl_dec;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_pc_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_funct3_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_funct3_q  <= ex_funct3_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rs1_val     = ex_rs1_val_q;
    assign ex_rs2_val     = ex_rs2_val_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rs1         = ex_rs1_q;
    assign ex_rs2         = ex_rs2_q;
    assign ex_rd          = ex_rd_q;
    assign ex_funct3      = ex_funct3_q;
    assign ex_alu_op      = ex_ctrl_q.alu_op;
    assign ex_alu_src_imm = ex_ctrl_q.alu_src_imm;
    assign ex_alu_src_pc  = ex_ctrl_q.alu_src_pc;
    assign ex_mem_read    = ex_ctrl_q.mem_read;
    assign ex_mem_write   = ex_ctrl_q.mem_write;
    assign ex_reg_write   = ex_ctrl_q.reg_write;
    assign ex_branch      = ex_ctrl_q.branch;
    assign ex_jump        = ex_ctrl_q.jump;
    assign ex_illegal     = ex_ctrl_q.illegal;

endmodule
